// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Brief   : MIPS-style HI/LO multiply/divide unit. Radix-2 shift-add multiply,
//           restoring divide; the divide path exists only with `MDU_DIV_EN.
// Rev     : 1.0  initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int              CW          = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   C_LAST      = CW'(WIDTH - 1);
    localparam logic [2:0]      C_ALU_RTYPE = 3'b010;
    localparam logic [5:0]      C_F_MFHI    = 6'b010000;
    localparam logic [5:0]      C_F_MTHI    = 6'b010001;
    localparam logic [5:0]      C_F_MFLO    = 6'b010010;
    localparam logic [5:0]      C_F_MTLO    = 6'b010011;
    localparam logic [5:0]      C_F_MULT    = 6'b011000;
    localparam logic [5:0]      C_F_MULTU   = 6'b011001;
`ifdef MDU_DIV_EN
    localparam logic [5:0]      C_F_DIV     = 6'b011010;
    localparam logic [5:0]      C_F_DIVU    = 6'b011011;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_done;
    logic                r_err;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_result;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_m;
    logic [WIDTH-1:0]    r_ph;
    logic [WIDTH-1:0]    r_pl;
    logic                r_sa;
    logic                r_sb;
`ifdef MDU_DIV_EN
    logic                r_div0;
    logic                r_isdiv;
`endif

    logic                w_req;
    logic                w_known;
    logic                w_is_mul;
    logic                w_is_mt;
    logic                w_sel_hi;
    logic                w_signed;
    logic                w_sa;
    logic                w_sb;
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_prod;
    logic [2*WIDTH-1:0]  w_prod_fix;
`ifdef MDU_DIV_EN
    logic                w_is_div;
    logic [WIDTH:0]      w_rsh;
    logic                w_ge;
    logic [WIDTH-1:0]    w_trial;
`endif

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        w_known  = 1'b1;
        w_is_mul = 1'b0;
        w_is_mt  = 1'b0;
        w_sel_hi = 1'b0;
        w_signed = 1'b0;
`ifdef MDU_DIV_EN
        w_is_div = 1'b0;
`endif
        case (funct_i)
            C_F_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            C_F_MULTU: w_is_mul = 1'b1;
`ifdef MDU_DIV_EN
            C_F_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
            C_F_DIVU:  w_is_div = 1'b1;
`endif
            C_F_MFHI:  w_sel_hi = 1'b1;
            C_F_MTHI:  begin w_sel_hi = 1'b1; w_is_mt = 1'b1; end
            C_F_MFLO:  w_sel_hi = 1'b0;
            C_F_MTLO:  w_is_mt = 1'b1;
            default:   w_known = 1'b0;
        endcase
    end

    assign w_req = valid_i & r_ready & (ALUOp_i == C_ALU_RTYPE);
    assign w_sa  = w_signed & src1_i[WIDTH-1];
    assign w_sb  = w_signed & src2_i[WIDTH-1];

    // Shift-add step: {r_ph, r_pl} is {partial product, remaining multiplier}.
    assign w_sum      = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;

`ifdef MDU_DIV_EN
    // Restoring step: remainder in r_ph, dividend bits shift out of r_pl as quotient shifts in.
    // The trial difference is always below the divisor, so WIDTH bits suffice.
    assign w_rsh   = {r_ph, r_pl[WIDTH-1]};
    assign w_ge    = (w_rsh >= {1'b0, r_m});
    assign w_trial = w_rsh[WIDTH-1:0] - r_m;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_m      <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
`ifdef MDU_DIV_EN
            r_div0   <= 1'b0;
            r_isdiv  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    if (w_req) begin
                        if (!w_known) begin
                            r_err <= 1'b1;
                        end else if (w_is_mul) begin
                            r_state <= S_MUL;
                            r_ready <= 1'b0;
                            r_cnt   <= '0;
                            r_ph    <= '0;
                            r_pl    <= f_abs(src2_i, w_sb);
                            r_m     <= f_abs(src1_i, w_sa);
                            r_sa    <= w_sa;
                            r_sb    <= w_sb;
`ifdef MDU_DIV_EN
                            r_isdiv <= 1'b0;
                        end else if (w_is_div) begin
                            r_state <= S_DIV;
                            r_ready <= 1'b0;
                            r_cnt   <= '0;
                            r_ph    <= '0;
                            r_pl    <= f_abs(src1_i, w_sa);
                            r_m     <= f_abs(src2_i, w_sb);
                            r_sa    <= w_sa;
                            r_sb    <= w_sb;
                            r_isdiv <= 1'b1;
                            r_div0  <= (src2_i == '0);
`endif
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            if (w_is_mt) begin
                                if (w_sel_hi) r_hi <= src1_i;
                                else          r_lo <= src1_i;
                            end else begin
                                r_result <= w_sel_hi ? r_hi : r_lo;
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_ph  <= w_sum[WIDTH:1];
                    r_pl  <= {w_sum[0], r_pl[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) r_state <= S_FIX;
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    if (r_div0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_ph  <= w_ge ? w_trial : w_rsh[WIDTH-1:0];
                        r_pl  <= {r_pl[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) r_state <= S_FIX;
                    end
                end
`endif
                S_FIX: begin
                    r_state <= S_DONE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
`ifdef MDU_DIV_EN
                    if (r_isdiv) begin
                        // Zero divisor: r_pl still holds |dividend|, so re-signing restores it.
                        if (r_div0) begin
                            r_hi <= r_sa ? -r_pl : r_pl;
                            r_lo <= '1;
                        end else begin
                            r_lo <= (r_sa ^ r_sb) ? -r_pl : r_pl;
                            r_hi <= r_sa ? -r_ph : r_ph;
                        end
                    end else
`endif
                    begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    assign result_o = r_result;
`ifdef MDU_DIV_EN
    assign div0_o   = r_div0;
`else
    assign div0_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Scoreboard bench for mul_div_unit (WIDTH=32); divide scenarios are
//           exercised when MDU_DIV_EN is defined, otherwise div must be rejected.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic [2:0]   ALUOp_i;
    logic [5:0]   funct_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic         ready_o;
    logic         done_o;
    logic         err_o;
    logic         div0_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic [W-1:0] result_o;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ALUOp_i  (ALUOp_i),
        .funct_i  (funct_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .div0_o   (div0_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .result_o (result_o)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_div0 = 1'b0;

    // Reference model; latency counts edges with the accept edge as edge 1.
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        int          sa;
        int          sbv;
        e.hi  = '0;
        e.lo  = '0;
        e.lat = W + 2;
        sa    = a;
        sbv   = b;
        case (f)
            F_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = p;
            end
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = p;
            end
            F_DIV, F_DIVU: begin
                if (b == '0) begin
                    e.lo  = '1;
                    e.hi  = a;
                    e.lat = 3;
                end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = a;
                    e.hi = '0;
                end else if (f == F_DIV) begin
                    e.lo = sa / sbv;
                    e.hi = sa % sbv;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Called at a negedge; holds the request until accepted, then scrambles operands.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int g = 0;
        while (ready_o !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_ready: ready_o=%b required 1", ready_o);
        end
        ALUOp_i = 3'b010;
        funct_i = f;
        src1_i  = a;
        src2_i  = b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
    endtask

    task automatic wait_done(output int edges, output bit seen);
        edges = 1;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b1;
        ALUOp_i = 3'b010;
        funct_i = F_MTHI;
        src1_i  = 32'h0000_DEAD;
        src2_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hi_o !== '0 || lo_o !== '0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h required 0 0", hi_o, lo_o);
        end
        n_checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || div0_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b done=%b err=%b div0=%b required 1 0 0 0",
                     ready_o, done_o, err_o, div0_o);
        end
        n_checks++;
        if (result_o !== '0) begin
            n_fail++;
            $display("FAIL reset_result: result=%h required 0", result_o);
        end
    endtask

    task automatic test_move();
        int lat;
        bit seen;
        issue(F_MTHI, 32'h0000_1234, 32'h0);
        wait_done(lat, seen);
        n_checks++;
        if (!seen || lat != 1 || hi_o !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mthi: seen=%b lat=%0d hi=%h required 1 1 00001234", seen, lat, hi_o);
        end
        issue(F_MTLO, 32'h0000_5678, 32'h0);
        wait_done(lat, seen);
        n_checks++;
        if (!seen || lo_o !== 32'h0000_5678 || hi_o !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mtlo: seen=%b lo=%h hi=%h required 1 00005678 00001234", seen, lo_o, hi_o);
        end
        issue(F_MFHI, 32'h0, 32'h0);
        wait_done(lat, seen);
        n_checks++;
        if (!seen || lat != 1 || result_o !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mfhi: seen=%b lat=%0d result=%h required 1 1 00001234", seen, lat, result_o);
        end
        issue(F_MFLO, 32'h0, 32'h0);
        wait_done(lat, seen);
        n_checks++;
        if (!seen || result_o !== 32'h0000_5678) begin
            n_fail++;
            $display("FAIL mflo: seen=%b result=%h required 1 00005678", seen, result_o);
        end
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b ready=%b required 0 1", done_o, ready_o);
        end
    endtask

    task automatic test_mult();
        for (int i = 0; i < 8; i++) begin
            logic [5:0]   f;
            logic [W-1:0] a;
            logic [W-1:0] b;
            exp_t         e;
            int           lat;
            bit           seen;
            case (i)
                0:       begin f = F_MULT;  a = 32'hFFFF_FFFD; b = 32'h0000_0005; end
                1:       begin f = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                2:       begin f = F_MULT;  a = 32'h8000_0000; b = 32'h8000_0000; end
                3:       begin f = F_MULT;  a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
                4:       begin f = F_MULTU; a = 32'h0000_0000; b = 32'h1234_5678; end
                default: begin f = i[0] ? F_MULTU : F_MULT; a = $urandom; b = $urandom; end
            endcase
            sb.push_back(model(f, a, b));
            issue(f, a, b);
            wait_done(lat, seen);
            e = sb.pop_front();
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL mult[%0d] timeout: done_o never rose", i);
            end
            n_checks++;
            if (hi_o !== e.hi || lo_o !== e.lo) begin
                n_fail++;
                $display("FAIL mult[%0d] hilo: got %h_%h required %h_%h", i, hi_o, lo_o, e.hi, e.lo);
            end
            n_checks++;
            if (lat != e.lat || div0_o !== exp_div0) begin
                n_fail++;
                $display("FAIL mult[%0d] lat/div0: got %0d %b required %0d %b", i, lat, div0_o, e.lat, exp_div0);
            end
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        for (int i = 0; i < 9; i++) begin
            logic [5:0]   f;
            logic [W-1:0] a;
            logic [W-1:0] b;
            exp_t         e;
            int           lat;
            bit           seen;
            case (i)
                0:       begin f = F_DIV;  a = 32'hFFFF_FFF9; b = 32'h0000_0002; end
                1:       begin f = F_DIVU; a = 32'h0000_0009; b = 32'h0000_0000; end
                2:       begin f = F_DIV;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       begin f = F_DIV;  a = 32'hFFFF_FFFB; b = 32'h0000_0000; end
                4:       begin f = F_DIVU; a = 32'hFFFF_FFFF; b = 32'h0000_0007; end
                5:       begin f = F_DIV;  a = 32'h0000_0007; b = 32'hFFFF_FFFE; end
                6:       begin f = F_DIVU; a = 32'h0000_0003; b = 32'h0000_0010; end
                default: begin f = i[0] ? F_DIVU : F_DIV; a = $urandom; b = $urandom_range(1, 65535); end
            endcase
            sb.push_back(model(f, a, b));
            exp_div0 = (b == '0);
            issue(f, a, b);
            wait_done(lat, seen);
            e = sb.pop_front();
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL div[%0d] timeout: done_o never rose", i);
            end
            n_checks++;
            if (hi_o !== e.hi || lo_o !== e.lo) begin
                n_fail++;
                $display("FAIL div[%0d] hilo: got %h_%h required %h_%h", i, hi_o, lo_o, e.hi, e.lo);
            end
            n_checks++;
            if (lat != e.lat || div0_o !== exp_div0) begin
                n_fail++;
                $display("FAIL div[%0d] lat/div0: got %0d %b required %0d %b", i, lat, div0_o, e.lat, exp_div0);
            end
        end
    endtask
`endif

    task automatic test_interlock();
        exp_t e;
        int   lat;
        bit   seen;
        issue(F_MTLO, 32'h0000_5678, 32'h0);
        wait_done(lat, seen);
        issue(F_MFLO, 32'h0, 32'h0);
        wait_done(lat, seen);
        sb.push_back(model(F_MULT, 32'h0001_0003, 32'hFFFF_0007));
        issue(F_MULT, 32'h0001_0003, 32'hFFFF_0007);
        funct_i = F_MFHI;
        valid_i = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0000_5678 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL interlock_busy: ready=%b result=%h done=%b required 0 00005678 0",
                     ready_o, result_o, done_o);
        end
        wait_done(lat, seen);
        e = sb.pop_front();
        n_checks++;
        if (!seen || hi_o !== e.hi || lo_o !== e.lo) begin
            n_fail++;
            $display("FAIL interlock_mult: seen=%b got %h_%h required %h_%h", seen, hi_o, lo_o, e.hi, e.lo);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b1 || result_o !== e.hi) begin
            n_fail++;
            $display("FAIL interlock_mfhi: done=%b result=%h required 1 %h", done_o, result_o, e.hi);
        end
    endtask

    task automatic test_unsupported();
        int lat;
        bit seen;
        issue(F_MTHI, 32'h1111_2222, 32'h0);
        wait_done(lat, seen);
        issue(F_MTLO, 32'h3333_4444, 32'h0);
        wait_done(lat, seen);
        for (int k = 0; k < 2; k++) begin
            logic [5:0] f;
            f = (k == 0) ? 6'b100000 : F_DIV;
`ifdef MDU_DIV_EN
            if (k == 1) break;
`endif
            @(negedge clk);
            issue(f, 32'h5555_5555, 32'h0000_0003);
            @(negedge clk);
            n_checks++;
            if (err_o !== 1'b1 || ready_o !== 1'b1 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL unsup[%0d] pulse: err=%b ready=%b done=%b required 1 1 0", k, err_o, ready_o, done_o);
            end
            n_checks++;
            if (hi_o !== 32'h1111_2222 || lo_o !== 32'h3333_4444 || div0_o !== 1'b0) begin
                n_fail++;
                $display("FAIL unsup[%0d] state: hi=%h lo=%h div0=%b required 11112222 33334444 0",
                         k, hi_o, lo_o, div0_o);
            end
            @(negedge clk);
            n_checks++;
            if (err_o !== 1'b0 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL unsup[%0d] width: err=%b done=%b required 0 0", k, err_o, done_o);
            end
        end
        // A non-R-type op class must be ignored entirely.
        ALUOp_i = 3'b000;
        funct_i = F_MTHI;
        src1_i  = 32'hFEED_BEEF;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hi_o !== 32'h1111_2222 || done_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_aluop: hi=%h done=%b err=%b required 11112222 0 0", hi_o, done_o, err_o);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        bit seen;
        bit done_seen;
        issue(F_MTHI, 32'h0000_AAAA, 32'h0);
        wait_done(lat, seen);
        issue(F_MFHI, 32'h0, 32'h0);
        wait_done(lat, seen);
        issue(F_MULT, 32'h0000_0123, 32'h0000_0456);
        repeat (10) @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_busy: ready=%b required 0", ready_o);
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b1 || hi_o !== '0 || lo_o !== '0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: ready=%b hi=%h lo=%h result=%h required 1 0 0 0",
                     ready_o, hi_o, lo_o, result_o);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) done_seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL midrst_nodone: done_o=1 seen required never");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_move();
        test_mult();
`ifdef MDU_DIV_EN
        test_div();
`endif
        test_interlock();
        test_unsupported();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
